// File: rtl/mem_pkg.sv
// Shared definitions for the memory alignment sequencer: RISC-V Funct3 codes,
// FSM states, access sizes and size/alignment helpers.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Unlisted encodings fall through to a full word access.
    function automatic size_t size_decode(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_B;
            F3_LH, F3_LHU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align_sequencer_if.sv
// Request/response and data-memory port bundle for the alignment sequencer.
// Handshake: a request completes on the rising edge where req_valid=1 and
// stall=0; while stall=1 the requester must hold every req_* input stable.
interface mem_align_sequencer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_read;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  stall;
    logic [DATA_W-1:0]     load_data;
    logic                  load_valid;
    logic                  dm_MemRead;
    logic                  dm_MemWrite;
    logic [DM_ADDRESS-1:0] dm_a;
    logic [DATA_W-1:0]     dm_wd;
    logic [2:0]            dm_Funct3;
    logic [DATA_W-1:0]     dm_rd;

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, dm_rd,
        output stall, load_data, load_valid, dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );

    modport master (
        output req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, dm_rd,
        input  stall, load_data, load_valid, dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );
endinterface

// File: rtl/load_extender.sv
// Selects a byte/half/word from a 64-bit two-word window at a byte offset and
// sign- or zero-extends it according to the load Funct3.
module load_extender
    import mem_pkg::*;
(
    input  logic [63:0] merged,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] window;

    assign window = merged[{1'b0, offset, 3'b000} +: 32];

    always_comb begin
        data = window;
        case (funct3)
            F3_LB:   data = {{24{window[7]}}, window[7:0]};
            F3_LH:   data = {{16{window[15]}}, window[15:0]};
            F3_LBU:  data = {24'b0, window[7:0]};
            F3_LHU:  data = {16'b0, window[15:0]};
            default: data = window;
        endcase
    end

endmodule

// File: rtl/mem_align_sequencer.sv
// Splits misaligned loads/stores into aligned data-memory accesses, stalling
// the pipeline until done; loads always go out as LW and are extended here.
module mem_align_sequencer
    import mem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_align_sequencer_if.slave      bus,
    output state_t                    state_dbg
);

    localparam logic [DM_ADDRESS-1:0] WORD_STEP = DM_ADDRESS'(4);

    state_t              state, state_n;
    logic [1:0]          cnt, cnt_n;
    logic [DATA_W-1:0]   lo_word, lo_word_n;
    size_t               size;
    logic                misaligned;
    logic                is_load;
    logic                is_store;
    logic [1:0]          last_cnt;
    logic [DM_ADDRESS-1:0] word_addr;
    logic [2*DATA_W-1:0] ext_in;
    logic [DATA_W-1:0]   ext_out;
    logic                load_valid_raw;

    assign size       = size_decode(bus.req_funct3);
    assign misaligned = is_misaligned(size, bus.req_addr[1:0]);
    assign word_addr  = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
    assign is_load    = bus.req_valid && bus.req_read;
    assign is_store   = bus.req_valid && !bus.req_read && bus.req_write;
    assign last_cnt   = (size == SZ_H) ? 2'd1 : 2'd3;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            lo_word <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lo_word <= lo_word_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        lo_word_n       = lo_word;
        bus.stall       = 1'b0;
        load_valid_raw  = 1'b0;
        bus.dm_MemRead  = 1'b0;
        bus.dm_MemWrite = 1'b0;
        bus.dm_a        = '0;
        bus.dm_wd       = '0;
        bus.dm_Funct3   = F3_LW;
        ext_in          = {{DATA_W{1'b0}}, bus.dm_rd};

        unique case (state)
            IDLE: begin
                if (is_load) begin
                    bus.dm_MemRead = 1'b1;
                    bus.dm_a       = word_addr;
                    if (misaligned) begin
                        bus.stall = 1'b1;
                        lo_word_n = bus.dm_rd;
                        state_n   = LD_HI;
                    end else begin
                        load_valid_raw = 1'b1;
                    end
                end else if (is_store) begin
                    bus.dm_MemWrite = 1'b1;
                    bus.dm_a        = bus.req_addr;
                    if (misaligned) begin
                        bus.dm_wd     = DATA_W'(bus.req_wdata[7:0]);
                        bus.dm_Funct3 = F3_SB;
                        bus.stall     = 1'b1;
                        cnt_n         = 2'd1;
                        state_n       = ST_BYTE;
                    end else begin
                        bus.dm_wd = bus.req_wdata;
                        case (size)
                            SZ_B:    bus.dm_Funct3 = F3_SB;
                            SZ_H:    bus.dm_Funct3 = F3_SH;
                            default: bus.dm_Funct3 = F3_SW;
                        endcase
                    end
                end
            end

            // Upper word of a misaligned load; address wraps silently at the top.
            LD_HI: begin
                bus.dm_MemRead = 1'b1;
                bus.dm_a       = word_addr + WORD_STEP;
                ext_in         = {bus.dm_rd, lo_word};
                load_valid_raw = 1'b1;
                state_n        = IDLE;
            end

            ST_BYTE: begin
                bus.dm_MemWrite = 1'b1;
                bus.dm_a        = bus.req_addr + DM_ADDRESS'(cnt);
                bus.dm_wd       = DATA_W'(bus.req_wdata[{cnt, 3'b000} +: 8]);
                bus.dm_Funct3   = F3_SB;
                if (cnt == last_cnt) begin
                    cnt_n   = 2'd0;
                    state_n = IDLE;
                end else begin
                    bus.stall = 1'b1;
                    cnt_n     = cnt + 2'd1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    load_extender u_ext (
        .merged (ext_in),
        .offset (bus.req_addr[1:0]),
        .funct3 (bus.req_funct3),
        .data   (ext_out)
    );

    // A load caught by reset never reports completion.
    assign bus.load_valid = load_valid_raw && !reset;
    assign bus.load_data  = bus.load_valid ? ext_out : '0;

endmodule

// File: tb/tb_mem_align_sequencer.sv
// Directed bench for mem_align_sequencer with a byte-array data memory model.
module tb_mem_align_sequencer;
    import mem_pkg::*;

    localparam int AW = 9;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;
    int     n_pass  = 0;
    int     n_total = 0;

    logic [7:0]    mem [0:511];
    logic [AW-1:0] wa;

    mem_align_sequencer_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus ();

    mem_align_sequencer #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Data memory: combinational word read, byte/half/word write on the edge.
    assign wa = {bus.dm_a[AW-1:2], 2'b00};
    assign bus.dm_rd = {mem[wa + 9'd3], mem[wa + 9'd2], mem[wa + 9'd1], mem[wa]};

    always @(posedge clk) begin
        if (bus.dm_MemWrite) begin
            mem[bus.dm_a] <= bus.dm_wd[7:0];
            if (bus.dm_Funct3 != F3_SB) mem[bus.dm_a + 9'd1] <= bus.dm_wd[15:8];
            if (bus.dm_Funct3 == F3_SW) begin
                mem[bus.dm_a + 9'd2] <= bus.dm_wd[23:16];
                mem[bus.dm_a + 9'd3] <= bus.dm_wd[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
        bus.req_valid  = 1'b1;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        #2;
    endtask

    task automatic no_req();
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        #2;
    endtask

    logic [AW-1:0] sw_addr_exp [4];
    logic [31:0]   sw_data_exp [4];
    logic          sw_stall_exp [4];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}   = 32'h80FF_1234;
        {mem[7], mem[6], mem[5], mem[4]}   = 32'hDDCC_BBAA;
        {mem[11], mem[10], mem[9], mem[8]} = 32'h4433_2211;
        mem[9'h1FF] = 8'h5A;

        sw_addr_exp  = '{9'h00D, 9'h00E, 9'h00F, 9'h010};
        sw_data_exp  = '{32'hD4, 32'hC3, 32'hB2, 32'hA1};
        sw_stall_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = F3_LW;
        tick();
        tick();
        #2;
        chk("rst_stall",      32'(bus.stall),       32'd0);
        chk("rst_load_valid", 32'(bus.load_valid),  32'd0);
        chk("rst_memread",    32'(bus.dm_MemRead),  32'd0);
        chk("rst_memwrite",   32'(bus.dm_MemWrite), 32'd0);
        chk("rst_dm_a",       32'(bus.dm_a),        32'd0);
        chk("rst_dm_wd",      bus.dm_wd,            32'd0);
        chk("rst_funct3",     32'(bus.dm_Funct3),   32'd2);
        chk("rst_load_data",  bus.load_data,        32'd0);
        chk("rst_state",      32'(state_dbg),       32'(IDLE));
        tick();
        reset = 1'b0;
        #1;

        // Aligned LB at 0x003, sign-extended.
        req(1'b1, 1'b0, 9'h003, 32'h0, F3_LB);
        chk("lb_dm_a",       32'(bus.dm_a),        32'h000);
        chk("lb_memread",    32'(bus.dm_MemRead),  32'd1);
        chk("lb_memwrite",   32'(bus.dm_MemWrite), 32'd0);
        chk("lb_stall",      32'(bus.stall),       32'd0);
        chk("lb_valid",      32'(bus.load_valid),  32'd1);
        chk("lb_data",       bus.load_data,        32'hFFFF_FF80);
        tick();

        // Misaligned LW at 0x006, two cycles.
        req(1'b1, 1'b0, 9'h006, 32'h0, F3_LW);
        chk("lw6_c1_stall", 32'(bus.stall),      32'd1);
        chk("lw6_c1_dm_a",  32'(bus.dm_a),       32'h004);
        chk("lw6_c1_valid", 32'(bus.load_valid), 32'd0);
        tick();
        #2;
        chk("lw6_c2_state", 32'(state_dbg),      32'(LD_HI));
        chk("lw6_c2_dm_a",  32'(bus.dm_a),       32'h008);
        chk("lw6_c2_stall", 32'(bus.stall),      32'd0);
        chk("lw6_c2_valid", 32'(bus.load_valid), 32'd1);
        chk("lw6_c2_data",  bus.load_data,       32'h2211_DDCC);
        tick();

        // Misaligned SW at 0x00D, four byte stores.
        req(1'b0, 1'b1, 9'h00D, 32'hA1B2_C3D4, F3_SW);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) #2;
            chk($sformatf("sw_b%0d_dm_a", k),   32'(bus.dm_a),        32'(sw_addr_exp[k]));
            chk($sformatf("sw_b%0d_wd", k),     bus.dm_wd,            sw_data_exp[k]);
            chk($sformatf("sw_b%0d_f3", k),     32'(bus.dm_Funct3),   32'(F3_SB));
            chk($sformatf("sw_b%0d_write", k),  32'(bus.dm_MemWrite), 32'd1);
            chk($sformatf("sw_b%0d_stall", k),  32'(bus.stall),       32'(sw_stall_exp[k]));
            tick();
        end

        // Aligned LW at 0x00C sees the bytes just written; LBU reaches 0x010.
        req(1'b1, 1'b0, 9'h00C, 32'h0, F3_LW);
        chk("lw_c_stall", 32'(bus.stall),   32'd0);
        chk("lw_c_data",  bus.load_data,    32'hB2C3_D400);
        tick();
        req(1'b1, 1'b0, 9'h010, 32'h0, F3_LBU);
        chk("lbu_10_data", bus.load_data, 32'h0000_00A1);
        tick();

        // Misaligned LHU at the top of memory wraps to word 0.
        req(1'b1, 1'b0, 9'h1FF, 32'h0, F3_LHU);
        chk("lhu_top_c1_dm_a",  32'(bus.dm_a),  32'h1FC);
        chk("lhu_top_c1_stall", 32'(bus.stall), 32'd1);
        tick();
        #2;
        chk("lhu_top_c2_dm_a", 32'(bus.dm_a),       32'h000);
        chk("lhu_top_c2_valid", 32'(bus.load_valid), 32'd1);
        chk("lhu_top_c2_data", bus.load_data,       32'h0000_345A);
        tick();

        // Misaligned SH at 0x031, then read back with a misaligned LHU.
        req(1'b0, 1'b1, 9'h031, 32'h0000_BEEF, F3_SH);
        chk("sh_b0_dm_a",  32'(bus.dm_a),  32'h031);
        chk("sh_b0_wd",    bus.dm_wd,      32'hEF);
        chk("sh_b0_stall", 32'(bus.stall), 32'd1);
        tick();
        #2;
        chk("sh_b1_dm_a",  32'(bus.dm_a),  32'h032);
        chk("sh_b1_wd",    bus.dm_wd,      32'hBE);
        chk("sh_b1_stall", 32'(bus.stall), 32'd0);
        tick();
        req(1'b1, 1'b0, 9'h031, 32'h0, F3_LHU);
        chk("lhu_31_c1_dm_a", 32'(bus.dm_a), 32'h030);
        tick();
        #2;
        chk("lhu_31_c2_dm_a", 32'(bus.dm_a), 32'h034);
        chk("lhu_31_c2_data", bus.load_data, 32'h0000_BEEF);
        tick();

        // Aligned LH at 0x006, negative half.
        req(1'b1, 1'b0, 9'h006, 32'h0, F3_LH);
        chk("lh_6_data", bus.load_data, 32'hFFFF_DDCC);
        tick();

        // Read flag without req_valid does nothing.
        bus.req_valid = 1'b0;
        #2;
        chk("novalid_memread",  32'(bus.dm_MemRead),  32'd0);
        chk("novalid_memwrite", 32'(bus.dm_MemWrite), 32'd0);
        chk("novalid_lvalid",   32'(bus.load_valid),  32'd0);
        tick();
        chk("novalid_state", 32'(state_dbg), 32'(IDLE));

        // Reset during the 2nd byte of a misaligned SW.
        req(1'b0, 1'b1, 9'h021, 32'h1122_3344, F3_SW);
        chk("swr_b0_dm_a", 32'(bus.dm_a), 32'h021);
        chk("swr_b0_wd",   bus.dm_wd,     32'h44);
        tick();
        reset = 1'b1;
        #2;
        chk("swr_b1_dm_a",  32'(bus.dm_a),        32'h022);
        chk("swr_b1_write", 32'(bus.dm_MemWrite), 32'd1);
        chk("swr_b1_wd",    bus.dm_wd,            32'h33);
        tick();
        reset = 1'b0;
        no_req();
        chk("swr_after_stall", 32'(bus.stall),       32'd0);
        chk("swr_after_state", 32'(state_dbg),       32'(IDLE));
        chk("swr_after_write", 32'(bus.dm_MemWrite), 32'd0);
        tick();
        req(1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        chk("swr_readback", bus.load_data, 32'h0033_4400);
        tick();
        req(1'b1, 1'b0, 9'h024, 32'h0, F3_LBU);
        chk("swr_byte3_untouched", bus.load_data, 32'h0000_0000);
        tick();

        // Back-to-back aligned SW then LW, req_valid held high.
        req(1'b0, 1'b1, 9'h040, 32'hCAFE_BABE, F3_SW);
        chk("b2b_sw_stall", 32'(bus.stall),     32'd0);
        chk("b2b_sw_dm_a",  32'(bus.dm_a),      32'h040);
        chk("b2b_sw_wd",    bus.dm_wd,          32'hCAFE_BABE);
        chk("b2b_sw_f3",    32'(bus.dm_Funct3), 32'(F3_SW));
        tick();
        req(1'b1, 1'b0, 9'h040, 32'h0, F3_LW);
        chk("b2b_lw_stall", 32'(bus.stall),       32'd0);
        chk("b2b_lw_write", 32'(bus.dm_MemWrite), 32'd0);
        chk("b2b_lw_data",  bus.load_data,        32'hCAFE_BABE);
        tick();
        no_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
